// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance stream monitor and its miter variants.
package mhd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_WORD_W = 1024;

    function automatic int hd_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_WORD_W-1:0] word);
        int unsigned count;
        count = 0;
        for (int i = 0; i < MAX_WORD_W; i++) begin
            count = count + int'(word[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational population count; the result width holds WIDTH exactly, so it never truncates.
module mhd_popcount
    import mhd_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int HD_W  = hd_width(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    output logic [HD_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + HD_W'(word[i]);
        end
    end

endmodule

// File: rtl/mhd_stream_monitor.sv
// Streams (exact, approximate) word pairs through a 2-stage Hamming-distance pipeline
// and accumulates run statistics into a pass/fail verdict.
module mhd_stream_monitor
    import mhd_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int MHD        = 4,
    parameter  int N_SAMPLES  = 1024,
    parameter  int ERR_BUDGET = 0,
    parameter  int CNT_W      = 32,
    localparam int HD_W       = hd_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             hd_valid,
    output logic [HD_W-1:0]  hd,
    output logic             viol,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] hd_sum,
    output logic [HD_W-1:0]  max_hd,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    localparam logic [CNT_W-1:0] N_CNT      = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] BUDGET_CNT = CNT_W'(ERR_BUDGET);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] acc_cnt;
    logic [WIDTH-1:0] diff_q;
    logic             v1;
    logic [HD_W-1:0]  pop;
    logic             pop_viol;
    logic             xfer;
    logic             start_run;
    logic [CNT_W-1:0] viol_cnt_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x,
                                                 input logic [CNT_W-1:0] y);
        logic [CNT_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    mhd_popcount #(.WIDTH(WIDTH)) u_popcount (
        .word  (diff_q),
        .count (pop)
    );

    assign pop_viol      = 32'(pop) > MHD;
    assign xfer          = in_valid && in_ready;
    assign start_run     = start && (state == IDLE || state == DONE);
    assign viol_cnt_next = (v1 && pop_viol) ? sat_add(viol_cnt, CNT_W'(1)) : viol_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (acc_cnt == N_CNT) state_next = DRAIN;
            DRAIN: if (!v1 && sample_cnt == N_CNT) state_next = DONE;
            DONE:  if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN) && (acc_cnt < N_CNT);
        busy     = (state == RUN) || (state == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q   <= '0;
            v1       <= 1'b0;
            hd_valid <= 1'b0;
            hd       <= '0;
            viol     <= 1'b0;
        end else begin
            v1       <= xfer;
            hd_valid <= v1;
            if (xfer) begin
                diff_q <= a ^ b;
            end
            if (v1) begin
                hd   <= pop;
                viol <= pop_viol;
            end
        end
    end

    // Statistics update on the same edge that publishes hd, from the same popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt    <= '0;
            sample_cnt <= '0;
            viol_cnt   <= '0;
            hd_sum     <= '0;
            max_hd     <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else if (start_run) begin
            acc_cnt    <= '0;
            sample_cnt <= '0;
            viol_cnt   <= '0;
            hd_sum     <= '0;
            max_hd     <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            if (xfer) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (v1) begin
                sample_cnt <= sat_add(sample_cnt, CNT_W'(1));
                viol_cnt   <= viol_cnt_next;
                hd_sum     <= sat_add(hd_sum, CNT_W'(pop));
                if (pop > max_hd) begin
                    max_hd <= pop;
                end
            end
            if (state == DRAIN && state_next == DONE) begin
                done <= 1'b1;
                fail <= viol_cnt_next > BUDGET_CNT;
            end
        end
    end

endmodule
